// File: rtl/bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : bus_arbiter_pkg
// Brief  : System address map and sequencer state encoding shared by the
//          two-master bus arbiter and the system bridge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bus_arbiter_pkg;

  // System address map (inclusive byte-address ranges)
  localparam logic [31:0] MAP_DM_BEGIN = 32'h0000_0000;
  localparam logic [31:0] MAP_DM_END   = 32'h0000_2FFF;
  localparam logic [31:0] MAP_T0_BEGIN = 32'h0000_7F00;
  localparam logic [31:0] MAP_T0_END   = 32'h0000_7F0B;
  localparam logic [31:0] MAP_T1_BEGIN = 32'h0000_7F10;
  localparam logic [31:0] MAP_T1_END   = 32'h0000_7F1B;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  // Inclusive range test used by the address decoder
  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// Module : rr_arb2
// Brief  : Two-input round-robin picker. A lone requester always wins; on
//          contention the requester that did not win last time is chosen.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot pick from the request vector, alternating on contention
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
//------------------------------------------------------------------------------
// Module : bus_arbiter
// Brief  : Two-master round-robin arbiter and access sequencer in front of the
//          system bridge. Each accepted request drives the bridge for one
//          cycle, is checked against the address map, and returns a one-cycle
//          registered response (data or error) to its owner.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [31:0] DM_BEGIN = MAP_DM_BEGIN,
  parameter logic [31:0] DM_END   = MAP_DM_END,
  parameter logic [31:0] T0_BEGIN = MAP_T0_BEGIN,
  parameter logic [31:0] T0_END   = MAP_T0_END,
  parameter logic [31:0] T1_BEGIN = MAP_T1_BEGIN,
  parameter logic [31:0] T1_END   = MAP_T1_END
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata
);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  byteen_q, byteen_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;

  logic        grant_window;
  logic [1:0]  arb_req;
  logic [1:0]  gnt;
  logic        is_dmem;
  logic        is_timer;
  logic        addr_err;

  // Grants are only offered outside ADDR; reset suppresses them so a master
  // never sees an acceptance for a request that is about to be discarded.
  assign grant_window = !reset && ((state_q == IDLE) || (state_q == RESP));
  assign arb_req      = grant_window ? {m1_req, m0_req} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req  (arb_req),
    .last (last_q),
    .gnt  (gnt)
  );

  // Address map check on the latched request; timers only take full-word or read
  always_comb begin
    is_dmem  = in_range(addr_q, DM_BEGIN, DM_END);
    is_timer = in_range(addr_q, T0_BEGIN, T0_END) ||
               in_range(addr_q, T1_BEGIN, T1_END);
    addr_err = !(is_dmem || is_timer) ||
               (is_timer && (byteen_q != 4'b0000) && (byteen_q != 4'b1111));
  end

  // Sequencer next state, request capture and response staging
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byteen_d    = byteen_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_err_d    = m0_err_q;
    m1_err_d    = m1_err_q;
    // The response pulse follows the single ADDR cycle of its owner
    m0_rvalid_d = (state_q == ADDR) && !owner_q;
    m1_rvalid_d = (state_q == ADDR) &&  owner_q;

    case (state_q)
      IDLE:    state_d = (|gnt) ? ADDR : IDLE;
      ADDR:    state_d = RESP;
      RESP:    state_d = (|gnt) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase

    if (|gnt) begin
      owner_d  = gnt[1];
      last_d   = gnt[1];
      addr_d   = gnt[1] ? m1_addr   : m0_addr;
      wdata_d  = gnt[1] ? m1_wdata  : m0_wdata;
      byteen_d = gnt[1] ? m1_byteen : m0_byteen;
    end

    if (state_q == ADDR) begin
      if (owner_q) begin
        m1_rdata_d = addr_err ? 32'h0 : bus_rdata;
        m1_err_d   = addr_err;
      end else begin
        m0_rdata_d = addr_err ? 32'h0 : bus_rdata;
        m0_err_d   = addr_err;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      byteen_q    <= 4'h0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byteen_q    <= byteen_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
    end
  end

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign m0_err     = m0_err_q;
  assign m1_err     = m1_err_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  // Write strobes reach the bridge only during ADDR and only for a legal access
  assign bus_byteen = ((state_q == ADDR) && !addr_err) ? byteen_q : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_bus_arbiter
// Brief  : Self-checking bench for bus_arbiter: directed single-access table,
//          contention and reset corner sequences, and randomized traffic
//          against a transaction-timeline reference model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_byteen  (m0_byteen),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_byteen  (m1_byteen),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .m1_err     (m1_err),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0; bus_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Reference address-map rules
  function automatic logic exp_err(input logic [31:0] a, input logic [3:0] be);
    logic dm, tm;
    dm = (a <= 32'h0000_2FFF);
    tm = ((a >= 32'h0000_7F00) && (a <= 32'h0000_7F0B)) ||
         ((a >= 32'h0000_7F10) && (a <= 32'h0000_7F1B));
    if (!dm && !tm) return 1'b1;
    if (tm && (be != 4'h0) && (be != 4'hF)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pick(output logic [31:0] a, output logic [3:0] be);
    case ($urandom_range(0, 6))
      0:       a = $urandom_range(0, 32'h2FFF);
      1:       a = 32'h7F00 + $urandom_range(0, 11);
      2:       a = 32'h7F10 + $urandom_range(0, 11);
      3:       a = 32'h7F0C + $urandom_range(0, 3);
      4:       a = 32'h3000 + $urandom_range(0, 32'h4EFF);
      5:       a = 32'h7F1C + $urandom_range(0, 3);
      default: a = $urandom;
    endcase
    case ($urandom_range(0, 2))
      0:       be = 4'h0;
      1:       be = 4'hF;
      default: be = 4'($urandom_range(0, 15));
    endcase
  endtask

  typedef struct packed {
    logic        m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] brd;
    logic        e_err;
    logic [3:0]  e_bbe;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [0:15];

  // Reference model state (random section)
  logic        act [2];
  logic [31:0] ra [2];
  logic [31:0] rw [2];
  logic [3:0]  rb [2];
  logic        prev_g, mlast, acc_v, acc_o, rsp_v, rsp_o;
  logic [31:0] acc_a, acc_w;
  logic [3:0]  acc_b;
  logic [31:0] hold_rd [2];
  logic        hold_err [2];

  initial begin
    vec_t        v;
    logic        eg0, eg1, e, w, slot, gown;
    logic [31:0] idx;
    int          n0, n1, j;

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 4'h0, 32'h1234_5678};
    vecs[1]  = '{1'b1, 32'h0000_8000, 32'hA5A5_A5A5, 4'hF, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_7F04, 32'h0000_0055, 4'h3, 32'h1111_1111, 1'b1, 4'h0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_7F04, 32'h0000_0055, 4'hF, 32'h0000_0011, 1'b0, 4'hF, 32'h0000_0011};
    vecs[4]  = '{1'b1, 32'h0000_2FFF, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 4'h0, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 32'h0000_3000, 32'h0,         4'h0, 32'h2222_2222, 1'b1, 4'h0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_7EFF, 32'h0,         4'h0, 32'h3333_3333, 1'b1, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_7F0B, 32'h0BAD_CAFE, 4'hF, 32'h4444_4444, 1'b0, 4'hF, 32'h4444_4444};
    vecs[8]  = '{1'b1, 32'h0000_7F0C, 32'h0,         4'h0, 32'h5555_5555, 1'b1, 4'h0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_7F10, 32'h1357_9BDF, 4'hF, 32'h6666_6666, 1'b0, 4'hF, 32'h6666_6666};
    vecs[10] = '{1'b1, 32'h0000_7F1B, 32'h0,         4'h0, 32'h7777_7777, 1'b0, 4'h0, 32'h7777_7777};
    vecs[11] = '{1'b0, 32'h0000_7F1C, 32'h0,         4'h0, 32'h8888_8888, 1'b1, 4'h0, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_7F18, 32'h0000_00FF, 4'h1, 32'h9999_9999, 1'b1, 4'h0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0100, 32'h0000_BEEF, 4'h3, 32'hAAAA_0001, 1'b0, 4'h3, 32'hAAAA_0001};
    vecs[14] = '{1'b1, 32'h0000_0000, 32'hFF00_0000, 4'h8, 32'hBBBB_0002, 1'b0, 4'h8, 32'hBBBB_0002};
    vecs[15] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hCCCC_0003, 1'b1, 4'h0, 32'h0};

    m0_addr = 32'h0; m0_wdata = 32'h0; m0_byteen = 4'h0;
    m1_addr = 32'h0; m1_wdata = 32'h0; m1_byteen = 4'h0;

    // Reset values, observed while reset is held
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0; bus_rdata = 32'h0;
    tick(); tick();
    chk("rst m0_rvalid", m0_rvalid, 0);  chk("rst m1_rvalid", m1_rvalid, 0);
    chk("rst m0_rdata", m0_rdata, 0);    chk("rst m1_rdata", m1_rdata, 0);
    chk("rst m0_err", m0_err, 0);        chk("rst m1_err", m1_err, 0);
    chk("rst bus_addr", bus_addr, 0);    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst bus_byteen", bus_byteen, 0);
    reset = 1'b0;

    // Directed single accesses: gnt at N, bus at N+1, response at N+2
    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      tick();
      m0_req = !v.m; m1_req = v.m; bus_rdata = 32'h0BAD_0000;
      if (v.m) begin m1_addr = v.addr; m1_wdata = v.wdata; m1_byteen = v.be; end
      else     begin m0_addr = v.addr; m0_wdata = v.wdata; m0_byteen = v.be; end
      #1;
      chk($sformatf("vec%0d owner gnt", i), v.m ? m1_gnt : m0_gnt, 1);
      chk($sformatf("vec%0d other gnt", i), v.m ? m0_gnt : m1_gnt, 0);
      tick();
      m0_req = 1'b0; m1_req = 1'b0; bus_rdata = v.brd;
      #1;
      chk($sformatf("vec%0d bus_byteen", i), bus_byteen, v.e_bbe);
      chk($sformatf("vec%0d bus_addr", i), bus_addr, v.addr);
      chk($sformatf("vec%0d bus_wdata", i), bus_wdata, v.wdata);
      tick();
      bus_rdata = ~v.brd;
      #1;
      chk($sformatf("vec%0d owner rvalid", i), v.m ? m1_rvalid : m0_rvalid, 1);
      chk($sformatf("vec%0d other rvalid", i), v.m ? m0_rvalid : m1_rvalid, 0);
      chk($sformatf("vec%0d rdata", i), v.m ? m1_rdata : m0_rdata, v.e_rd);
      chk($sformatf("vec%0d err", i), v.m ? m1_err : m0_err, v.e_err);
    end
    tick();
    #1;
    chk("hold m0_rvalid", m0_rvalid, 0);
    chk("hold m0_rdata", m0_rdata, vecs[13].e_rd);
    chk("hold m1_err", m1_err, 1);

    // Both masters stream 4 writes each from reset: strict alternation from m0
    do_reset();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 18; c++) begin
      tick();
      m0_req = (c <= 12); m1_req = (c <= 14);
      m0_addr = 32'h200 + 4 * ((c + 3) / 4); m0_wdata = 32'hA000_0000 + (c + 3) / 4; m0_byteen = 4'hF;
      m1_addr = 32'h400 + 4 * ((c + 1) / 4); m1_wdata = 32'hB000_0000 + (c + 1) / 4; m1_byteen = 4'hF;
      bus_rdata = 32'h1000 + c;
      #1;
      slot = (c % 2 == 0) && (c < 16);
      gown = ((c / 2) % 2) == 1;
      chk($sformatf("rr c%0d m0_gnt", c), m0_gnt, slot && !gown);
      chk($sformatf("rr c%0d m1_gnt", c), m1_gnt, slot && gown);
      if (m0_gnt) n0++;
      if (m1_gnt) n1++;
      if ((c % 2 == 1) && (c < 16)) begin
        j = (c - 1) / 2;
        idx = j / 2;
        chk($sformatf("rr c%0d bus_byteen", c), bus_byteen, 4'hF);
        chk($sformatf("rr c%0d bus_addr", c), bus_addr, (j % 2 == 1) ? 32'h400 + 4 * idx : 32'h200 + 4 * idx);
        chk($sformatf("rr c%0d bus_wdata", c), bus_wdata, (j % 2 == 1) ? 32'hB000_0000 + idx : 32'hA000_0000 + idx);
      end else begin
        chk($sformatf("rr c%0d bus_byteen idle", c), bus_byteen, 4'h0);
      end
      if ((c % 2 == 0) && (c >= 2) && (c < 18)) begin
        j = (c - 2) / 2;
        chk($sformatf("rr c%0d m0_rvalid", c), m0_rvalid, (j % 2) == 0);
        chk($sformatf("rr c%0d m1_rvalid", c), m1_rvalid, (j % 2) == 1);
        chk($sformatf("rr c%0d rdata", c), (j % 2 == 1) ? m1_rdata : m0_rdata, 32'h1000 + c - 1);
      end else begin
        chk($sformatf("rr c%0d no rvalid", c), {m1_rvalid, m0_rvalid}, 0);
      end
    end
    chk("rr m0 grant count", n0, 4);
    chk("rr m1 grant count", n1, 4);

    // Reset during the ADDR cycle of an m1 write discards it
    do_reset();
    tick();
    m1_req = 1'b1; m1_addr = 32'h300; m1_wdata = 32'h5A5A_5A5A; m1_byteen = 4'hF;
    #1;
    chk("rstmid m1_gnt", m1_gnt, 1);
    tick();
    m1_req = 1'b0; reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid m1_rvalid", m1_rvalid, 0);
    chk("rstmid bus_byteen", bus_byteen, 0);
    tick();
    #1;
    chk("rstmid m1_rvalid later", m1_rvalid, 0);
    chk("rstmid bus_byteen later", bus_byteen, 0);
    tick();
    m0_req = 1'b1; m0_addr = 32'h10; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h20; m1_byteen = 4'h0;
    #1;
    chk("rstmid m0 wins", m0_gnt, 1);
    chk("rstmid m1 waits", m1_gnt, 0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();

    // Randomized traffic against the timeline model
    do_reset();
    act[0] = 0; act[1] = 0; prev_g = 0; mlast = 1; acc_v = 0; acc_o = 0; rsp_v = 0; rsp_o = 0;
    acc_a = 0; acc_w = 0; acc_b = 0;
    hold_rd[0] = 0; hold_rd[1] = 0; hold_err[0] = 0; hold_err[1] = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && ($urandom_range(0, 2) == 0)) begin
          act[m] = 1'b1;
          pick(ra[m], rb[m]);
          rw[m] = $urandom;
        end
      end
      m0_req = act[0]; m0_addr = ra[0]; m0_wdata = rw[0]; m0_byteen = rb[0];
      m1_req = act[1]; m1_addr = ra[1]; m1_wdata = rw[1]; m1_byteen = rb[1];
      bus_rdata = $urandom;
      #1;
      eg0 = 0; eg1 = 0;
      if (!prev_g) begin
        if (act[0] && act[1]) begin eg0 = mlast; eg1 = !mlast; end
        else begin eg0 = act[0]; eg1 = act[1]; end
      end
      chk($sformatf("rnd c%0d m0_gnt", c), m0_gnt, eg0);
      chk($sformatf("rnd c%0d m1_gnt", c), m1_gnt, eg1);
      e = acc_v ? exp_err(acc_a, acc_b) : 1'b0;
      chk($sformatf("rnd c%0d bus_byteen", c), bus_byteen, (acc_v && !e) ? acc_b : 4'h0);
      if (acc_v) begin
        chk($sformatf("rnd c%0d bus_addr", c), bus_addr, acc_a);
        chk($sformatf("rnd c%0d bus_wdata", c), bus_wdata, acc_w);
      end
      chk($sformatf("rnd c%0d m0_rvalid", c), m0_rvalid, rsp_v && !rsp_o);
      chk($sformatf("rnd c%0d m1_rvalid", c), m1_rvalid, rsp_v && rsp_o);
      chk($sformatf("rnd c%0d m0_rdata", c), m0_rdata, hold_rd[0]);
      chk($sformatf("rnd c%0d m1_rdata", c), m1_rdata, hold_rd[1]);
      chk($sformatf("rnd c%0d m0_err", c), m0_err, hold_err[0]);
      chk($sformatf("rnd c%0d m1_err", c), m1_err, hold_err[1]);
      rsp_v = acc_v; rsp_o = acc_o;
      if (acc_v) begin
        hold_rd[acc_o]  = e ? 32'h0 : bus_rdata;
        hold_err[acc_o] = e;
      end
      acc_v = eg0 | eg1;
      if (eg0 | eg1) begin
        w = eg1;
        acc_o = w; acc_a = ra[w]; acc_w = rw[w]; acc_b = rb[w];
        act[w] = 1'b0;
        mlast = w;
      end
      prev_g = eg0 | eg1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the system bridge.
- m0 is the CPU data port; m1 is a secondary bus master (DMA/debug).
- Serialises accesses onto the single bridge port, round-robin.
- Checks each address against the system address map and returns a registered response (data or error) to the owning master.

Parameters:
- DM_BEGIN, 32'h0000_0000, first data-memory byte address
- DM_END, 32'h0000_2FFF, last data-memory byte address
- T0_BEGIN, 32'h0000_7F00, first Timer0 register address
- T0_END, 32'h0000_7F0B, last Timer0 register address
- T1_BEGIN, 32'h0000_7F10, first Timer1 register address
- T1_END, 32'h0000_7F1B, last Timer1 register address

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  m0 request; held with fields stable until m0_gnt
- m0_addr  in  32  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_byteen  in  4  m0 byte enables; 4'b0000 = read
- m0_gnt  out  1  m0 request accepted this cycle (combinational)
- m0_rvalid  out  1  one-cycle response pulse to m0
- m0_rdata  out  32  m0 read data, valid with m0_rvalid
- m0_err  out  1  m0 access error, valid with m0_rvalid
- m1_req, m1_addr, m1_wdata, m1_byteen, m1_gnt, m1_rvalid, m1_rdata, m1_err: same widths and meanings for m1
- bus_addr  out  32  address to bridge
- bus_wdata  out  32  write data to bridge
- bus_byteen  out  4  byte enables to bridge; nonzero only in ADDR for a legal write
- bus_rdata  in  32  combinational read data from bridge

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, last=1 (m0 wins first contention)
  - all rvalid/err=0, rdata=0
  - bus_byteen=0, bus_addr=0, bus_wdata=0
- States:
  - IDLE: no transaction in flight.
  - ADDR: the latched request drives the bus for exactly one cycle.
  - RESP: the response pulse is presented to the owner.
- Grant:
  - gnt may assert only in IDLE or RESP, for at most one master per cycle.
  - One requester: it wins.
  - Both requesting: grant the master != last.
  - On gnt: latch addr/wdata/byteen/owner, set last=owner, next state=ADDR.
- ADDR:
  - Drive bus_addr and bus_wdata from the latched request.
  - Register bus_rdata, or 0 on error, into the owner's rdata at the clock edge.
  - Next state=RESP.
- RESP:
  - owner rvalid=1 for exactly this cycle, err as decoded.
  - Next state=ADDR if a gnt is issued this cycle, else IDLE.
- Timing:
  - Latency is gnt at cycle N, bus access at N+1, rvalid at N+2.
  - Peak throughput is one transaction per 2 cycles.
- Error decode (on the latched address):
  - err=1 if the address lies outside all three ranges (inclusive compares).
  - err=1 if the address is a timer address and byteen is neither 4'b0000 nor 4'b1111.
  - On error, bus_byteen is forced to 0 (no side effect) and rdata=0.
- Non-owner rvalid stays 0. rdata/err hold their last value when rvalid=0.
- gnt is never issued in ADDR. A request arriving then waits; no request is dropped.
- Reset mid-operation: the in-flight transaction is discarded with no rvalid, and a pending write never reaches the bus after reset.
- Back-to-back from one master: after its gnt, a competing other master wins the next slot (round-robin). With no competition, the same master is re-granted in RESP.

Decomposition:
- Shared macro/package holds:
  - the six address-map constants, shared with the bridge
  - state encodings IDLE=2'd0, ADDR=2'd1, RESP=2'd2
- One natural sub-module, rr_arb2: a 2-input round-robin picker (req[1:0], last → gnt[1:0]).
- Address-range decode stays inline.

Test Plan:
- Single m0 read of 0x0000_0010, bus_rdata=0x1234_5678 → m0_gnt at N, bus_byteen=0 at N+1, m0_rvalid=1, m0_rdata=0x1234_5678, m0_err=0 at N+2.
- m0 and m1 both request writes from IDLE after reset → m0 granted first; m1 granted in m0's RESP cycle; the two writes appear on the bus 2 cycles apart with byteen=4'b1111.
- m1 write 0x0000_8000, byteen=4'b1111 → bus_byteen stays 0; m1_rvalid=1, m1_err=1, m1_rdata=0.
- m0 write to 0x0000_7F04 with byteen=4'b0011 → bus_byteen=0, m0_err=1; the same access with byteen=4'b1111 → bus_byteen=4'b1111, m0_err=0.
- Both masters hold req continuously for 8 transactions → grants alternate m0,m1,m0,…; each master gets exactly 4; no rvalid to a non-owner.
- Reset asserted in the ADDR cycle of an m1 write → no m1_rvalid afterward, bus_byteen=0 the following cycle, state IDLE, and next contention goes to m0.
